// File: rtl/vram_vga_fetch_if.sv
// Purpose: bundles the pixel-consumer and VRAM read-port signals of the VGA fetch block.
// Latency: none, wires only.
// Backpressure: pixel_req pulls one pixel; vram_vga_ready answers a req exactly one cycle later.
interface vram_vga_fetch_if;
   logic        frame_start;
   logic        pixel_req;
   logic        pixel_out;
   logic        pixel_valid;
   logic [14:0] vram_vga_addr;
   logic        vram_vga_req;
   logic        vram_vga_ready;
   logic [31:0] vram_vga_data_in;
   logic        underflow;
   logic [15:0] underflow_count;

   // Fetch block side.
   modport slave (
      input  frame_start, pixel_req, vram_vga_ready, vram_vga_data_in,
      output pixel_out, pixel_valid, vram_vga_addr, vram_vga_req, underflow, underflow_count
   );

   // Display timing / VRAM side.
   modport master (
      output frame_start, pixel_req, vram_vga_ready, vram_vga_data_in,
      input  pixel_out, pixel_valid, vram_vga_addr, vram_vga_req, underflow, underflow_count
   );
endinterface

// File: rtl/vram_vga_fetch.sv
// Purpose: streams one frame of 32-bit VRAM words through a small FIFO into a 1-bit pixel shifter.
// Latency: word lands in FIFO 2 cycles after req; shifter loads from FIFO (or bypass) same cycle it empties.
// Backpressure: req issues only with a free FIFO slot; pixel_req with no data flags sticky underflow.
// Optional: define VRAM_VGA_FETCH_STATS_EN for the saturating underflow event counter.
module vram_vga_fetch #(
   parameter int WORDS_PER_FRAME = 21504,
   parameter int FIFO_DEPTH      = 4
) (
   input  logic            clk,
   input  logic            reset,
   vram_vga_fetch_if.slave bus
);

   localparam int               PTR_W     = $clog2(FIFO_DEPTH);
   localparam int               CNT_W     = PTR_W + 1;
   localparam logic [14:0]      LAST_ADDR = 15'(WORDS_PER_FRAME - 1);
   localparam logic [CNT_W-1:0] DEPTH_C   = CNT_W'(FIFO_DEPTH);

   typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

   state_t           state_q, state_d;
   logic [14:0]      addr_q, addr_d;
   logic [31:0]      mem_q [FIFO_DEPTH];
   logic [31:0]      mem_d [FIFO_DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] fifo_cnt_q, fifo_cnt_d;
   logic [31:0]      sh_dat_q, sh_dat_d;
   logic [5:0]       sh_cnt_q, sh_cnt_d;
   logic             underflow_q, underflow_d;

   logic             vram_req;
   logic             fifo_wr;
   logic             fifo_rd;
   logic             sh_vld;
   logic             consume;
   logic             starve;
   logic             sh_empty_nxt;
   logic [31:0]      fifo_head;

   assign sh_vld       = (sh_cnt_q != 6'd0);
   assign consume      = bus.pixel_req && sh_vld;
   assign starve       = bus.pixel_req && !sh_vld;
   // Shifter is free for a new word if empty now or its last bit is taken this cycle,
   // so a steady pixel_req stream sees no bubble at word boundaries.
   assign sh_empty_nxt = !sh_vld || ((sh_cnt_q == 6'd1) && bus.pixel_req);
   // An empty FIFO being written passes the incoming word straight through.
   assign fifo_head    = (fifo_cnt_q == '0) ? bus.vram_vga_data_in : mem_q[rd_ptr_q];
   assign fifo_rd      = sh_empty_nxt && !bus.frame_start && ((fifo_cnt_q != '0) || fifo_wr);

   // Fetch FSM: next state, address and request. Only one read is ever in flight, and REQ
   // waits for a free slot, so the returning word always has room.
   always_comb begin
      state_d  = state_q;
      addr_d   = addr_q;
      vram_req = 1'b0;
      fifo_wr  = 1'b0;
      if (bus.frame_start) begin
         // Restart from any state; a ready for an aborted read lands in REQ and is ignored.
         state_d = REQ;
         addr_d  = '0;
      end else begin
         unique case (state_q)
            REQ: begin
               if (fifo_cnt_q < DEPTH_C) begin
                  vram_req = 1'b1;
                  state_d  = WAIT;
               end
            end
            WAIT: begin
               if (bus.vram_vga_ready) begin
                  fifo_wr = 1'b1;
                  if (addr_q == LAST_ADDR) begin
                     state_d = DONE;
                  end else begin
                     addr_d  = addr_q + 15'd1;
                     state_d = REQ;
                  end
               end
            end
            default: ;
         endcase
      end
   end

   // FIFO storage/pointers and pixel shifter; frame_start flushes everything.
   always_comb begin
      mem_d      = mem_q;
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      fifo_cnt_d = fifo_cnt_q;
      sh_dat_d   = sh_dat_q;
      sh_cnt_d   = sh_cnt_q;
      if (bus.frame_start) begin
         wr_ptr_d   = '0;
         rd_ptr_d   = '0;
         fifo_cnt_d = '0;
         sh_dat_d   = '0;
         sh_cnt_d   = '0;
      end else begin
         if (fifo_wr) begin
            mem_d[wr_ptr_q] = bus.vram_vga_data_in;
            wr_ptr_d        = wr_ptr_q + 1'b1;
         end
         if (fifo_rd) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
            sh_dat_d = fifo_head;
            sh_cnt_d = 6'd32;
         end else if (consume) begin
            sh_dat_d = sh_dat_q >> 1;
            sh_cnt_d = sh_cnt_q - 6'd1;
         end
         fifo_cnt_d = fifo_cnt_q + CNT_W'(fifo_wr) - CNT_W'(fifo_rd);
      end
   end

   // Sticky underflow: cleared by frame_start, but a starved request in that same cycle still counts.
   always_comb begin
      underflow_d = underflow_q;
      if (bus.frame_start) begin
         underflow_d = 1'b0;
      end
      if (starve) begin
         underflow_d = 1'b1;
      end
   end

   // State register; reset abandons any read in flight.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= IDLE;
         addr_q      <= '0;
         mem_q       <= '{default: '0};
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         fifo_cnt_q  <= '0;
         sh_dat_q    <= '0;
         sh_cnt_q    <= '0;
         underflow_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         addr_q      <= addr_d;
         mem_q       <= mem_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         fifo_cnt_q  <= fifo_cnt_d;
         sh_dat_q    <= sh_dat_d;
         sh_cnt_q    <= sh_cnt_d;
         underflow_q <= underflow_d;
      end
   end

   assign bus.vram_vga_req  = vram_req;
   assign bus.vram_vga_addr = addr_q;
   assign bus.pixel_valid   = sh_vld;
   assign bus.pixel_out     = sh_vld && sh_dat_q[0];
   assign bus.underflow     = underflow_q;

`ifdef VRAM_VGA_FETCH_STATS_EN
   logic [15:0] uf_cnt_q, uf_cnt_d;

   // Saturating count of starved pixel requests; survives frame_start.
   always_comb begin
      uf_cnt_d = uf_cnt_q;
      if (starve && (uf_cnt_q != 16'hffff)) begin
         uf_cnt_d = uf_cnt_q + 16'd1;
      end
   end

   // Counter register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         uf_cnt_q <= '0;
      end else begin
         uf_cnt_q <= uf_cnt_d;
      end
   end

   assign bus.underflow_count = uf_cnt_q;
`else
   assign bus.underflow_count = '0;
`endif

endmodule

// File: tb/tb_vram_vga_fetch.sv
// Purpose: directed, table-driven checks of vram_vga_fetch with a one-cycle-latency VRAM model.
// Latency: VRAM model answers a req sampled in cycle k with ready/data in cycle k+1.
// Backpressure: model can withhold replies or inject extra (stale) ready pulses on demand.
module tb_vram_vga_fetch;

   localparam int WPF = 6;   // short frame keeps the run small; end-of-frame logic is the same
   localparam int NV  = 44;

   typedef struct {
      logic req;
      logic exp_out;
      logic exp_vld;
   } vec_t;

   logic clk;
   logic reset;
   vram_vga_fetch_if bus ();

   vram_vga_fetch #(.WORDS_PER_FRAME(WPF), .FIFO_DEPTH(4)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   int          nvec = 0;
   int          nmis = 0;
   logic        withhold;
   logic        extra_rdy;
   logic [31:0] extra_dat;
   logic [14:0] req_log[$];
   vec_t        vecs[NV];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Address-tagged word so every word and every bit position is distinguishable.
   function automatic logic [31:0] word_of(input logic [14:0] a);
      return 32'h9E37_79B9 ^ {a, 2'b01, a};
   endfunction

   function automatic logic pix(input int p);
      logic [31:0] w;
      w = word_of(15'(p / 32));
      return w[p % 32];
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      nvec++;
      if (act !== exp) begin
         nmis++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic chk_reset(input string tag);
      chk({tag, " req"}, 32'(bus.vram_vga_req), 32'd0);
      chk({tag, " addr"}, 32'(bus.vram_vga_addr), 32'd0);
      chk({tag, " pixel_out"}, 32'(bus.pixel_out), 32'd0);
      chk({tag, " pixel_valid"}, 32'(bus.pixel_valid), 32'd0);
      chk({tag, " underflow"}, 32'(bus.underflow), 32'd0);
      chk({tag, " underflow_count"}, 32'(bus.underflow_count), 32'd0);
   endtask

   // Called at a negedge; returns at the negedge where pixel_valid is seen, or flags a timeout.
   task automatic wait_valid(input string name);
      int n;
      n = 0;
      while (bus.pixel_valid !== 1'b1 && n < 50) begin
         @(negedge clk);
         n++;
      end
      chk({name, " valid within budget"}, 32'(bus.pixel_valid), 32'd1);
   endtask

   // VRAM model: capture req/addr mid-cycle, answer just after the next edge.
   initial begin
      logic        r;
      logic [14:0] a;
      bus.vram_vga_ready   = 1'b0;
      bus.vram_vga_data_in = '0;
      forever begin
         @(negedge clk);
         r = (bus.vram_vga_req === 1'b1) && !withhold;
         a = bus.vram_vga_addr;
         @(posedge clk);
         #1;
         bus.vram_vga_ready   = r || extra_rdy;
         bus.vram_vga_data_in = extra_rdy ? extra_dat : word_of(a);
      end
   end

   // Request monitor.
   initial begin
      forever begin
         @(negedge clk);
         if (bus.vram_vga_req === 1'b1) req_log.push_back(bus.vram_vga_addr);
      end
   end

   // Watchdog.
   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int          p;
      logic [31:0] xw;
      logic [31:0] got;

      reset           = 1'b1;
      bus.frame_start = 1'b0;
      bus.pixel_req   = 1'b0;
      withhold        = 1'b0;
      extra_rdy       = 1'b0;
      extra_dat       = '0;

      // Pixel table: word 0 streamed back to back (crossing into word 1 with no bubble),
      // then word 1 with some idle cycles in which the current pixel must hold.
      p = 0;
      for (int i = 0; i < NV; i++) begin
         vecs[i].req     = (i < 32) ? 1'b1 : ((i % 3) != 1);
         vecs[i].exp_out = pix(p);
         vecs[i].exp_vld = 1'b1;
         if (vecs[i].req) p++;
      end

      // Reset values.
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk_reset("reset");

      // Start a frame with no consumer: exactly DEPTH+1 words fetched, in order.
      @(posedge clk); #2; reset = 1'b0;
      @(posedge clk); #2; bus.frame_start = 1'b1;
      @(posedge clk); #2; bus.frame_start = 1'b0;
      repeat (40) @(posedge clk);
      @(negedge clk); #1;
      chk("prefetch word count", 32'(req_log.size()), 32'd5);
      for (int i = 0; i < 5 && i < req_log.size(); i++) chk("prefetch addr order", 32'(req_log[i]), 32'(i));
      chk("first pixel valid", 32'(bus.pixel_valid), 32'd1);
      chk("first pixel value", 32'(bus.pixel_out), 32'(pix(0)));
      repeat (20) @(negedge clk);
      #1;
      chk("prefetch stalls", 32'(req_log.size()), 32'd5);
      chk("req low when full", 32'(bus.vram_vga_req), 32'd0);

      // Table-driven pixel stream.
      for (int i = 0; i < NV; i++) begin
         @(posedge clk); #2;
         bus.pixel_req = vecs[i].req;
         @(negedge clk);
         chk($sformatf("vec%0d pixel_out", i), 32'(bus.pixel_out), 32'(vecs[i].exp_out));
         chk($sformatf("vec%0d pixel_valid", i), 32'(bus.pixel_valid), 32'(vecs[i].exp_vld));
      end

      // Drain the rest of the frame with continuous requests.
      while (p < WPF * 32) begin
         @(posedge clk); #2;
         bus.pixel_req = 1'b1;
         @(negedge clk);
         chk($sformatf("frame pixel %0d", p), {bus.pixel_valid, bus.pixel_out}, {1'b1, pix(p)});
         p++;
      end
      @(posedge clk); #2; bus.pixel_req = 1'b0;
      repeat (10) @(negedge clk);
      #1;
      chk("frame word count", 32'(req_log.size()), 32'(WPF));
      for (int i = 0; i < WPF && i < req_log.size(); i++) chk("frame addr order", 32'(req_log[i]), 32'(i));
      chk("done: no req", 32'(bus.vram_vga_req), 32'd0);
      chk("done: addr at last word", 32'(bus.vram_vga_addr), 32'(WPF - 1));
      chk("done: underflow clear", 32'(bus.underflow), 32'd0);

      // Starvation: one hand-fed word, then the model stops answering.
      @(posedge clk); #2; withhold = 1'b1; bus.frame_start = 1'b1;
      @(posedge clk); #2; bus.frame_start = 1'b0;
      @(negedge clk);
      chk("starve: first req", 32'(bus.vram_vga_req), 32'd1);
      chk("starve: first addr", 32'(bus.vram_vga_addr), 32'd0);
      xw        = 32'hC3A5_5A3C;
      extra_rdy = 1'b1;
      extra_dat = xw;
      @(posedge clk); #2; extra_rdy = 1'b0;
      @(negedge clk);
      wait_valid("starve");
      for (int i = 0; i < 42; i++) begin
         @(posedge clk); #2;
         bus.pixel_req = 1'b1;
         @(negedge clk);
         if (i < 32) chk($sformatf("starve pixel %0d", i), {bus.pixel_valid, bus.pixel_out}, {1'b1, xw[i]});
         else        chk($sformatf("starved req %0d", i), {bus.pixel_valid, bus.pixel_out}, 2'b00);
      end
      @(posedge clk); #2; bus.pixel_req = 1'b0;
      @(negedge clk);
      chk("starve: underflow set", 32'(bus.underflow), 32'd1);
`ifdef VRAM_VGA_FETCH_STATS_EN
      chk("starve: underflow_count", 32'(bus.underflow_count), 32'd10);
`else
      chk("starve: underflow_count", 32'(bus.underflow_count), 32'd0);
`endif

      // frame_start while waiting; a stale ready with DEADBEEF follows and must be dropped.
      @(posedge clk); #2; bus.frame_start = 1'b1;
      @(negedge clk);
      extra_rdy = 1'b1;
      extra_dat = 32'hdeadbeef;
      @(posedge clk); #2; bus.frame_start = 1'b0;
      @(negedge clk);
      chk("abort: restart req", 32'(bus.vram_vga_req), 32'd1);
      chk("abort: restart addr", 32'(bus.vram_vga_addr), 32'd0);
      chk("abort: underflow cleared", 32'(bus.underflow), 32'd0);
      chk("abort: shifter flushed", 32'(bus.pixel_valid), 32'd0);
`ifdef VRAM_VGA_FETCH_STATS_EN
      chk("abort: count kept", 32'(bus.underflow_count), 32'd10);
`else
      chk("abort: count kept", 32'(bus.underflow_count), 32'd0);
`endif
      extra_dat = word_of(15'd0);
      @(posedge clk); #2; extra_rdy = 1'b0; withhold = 1'b0;
      @(negedge clk);
      wait_valid("abort");
      got = '0;
      for (int i = 0; i < 32; i++) begin
         @(posedge clk); #2;
         bus.pixel_req = 1'b1;
         @(negedge clk);
         got[i] = bus.pixel_out;
      end
      @(posedge clk); #2; bus.pixel_req = 1'b0;
      chk("abort: first word is word 0", got, word_of(15'd0));

      // Reset with a read in flight; a later ready must not write the FIFO.
      @(posedge clk); #2; bus.frame_start = 1'b1;
      @(posedge clk); #2; bus.frame_start = 1'b0;
      @(negedge clk);
      chk("inflight: req issued", 32'(bus.vram_vga_req), 32'd1);
      @(posedge clk); #2; reset = 1'b1;
      @(negedge clk);
      chk_reset("mid-fetch reset");
      @(posedge clk); #2; reset = 1'b0; extra_rdy = 1'b1; extra_dat = 32'hdeadbeef;
      @(posedge clk); #2; extra_rdy = 1'b0;
      repeat (5) @(negedge clk);
      chk("post-reset: no pixel data", 32'(bus.pixel_valid), 32'd0);
      chk("post-reset: idle req", 32'(bus.vram_vga_req), 32'd0);
      chk("post-reset: addr", 32'(bus.vram_vga_addr), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
      $finish;
   end

endmodule
